// File: rtl/conv33_window_gen_if.sv
// Pixel-in / 3x3-window-out handshake bundle for conv33_window_gen.
// The slave modport is the window generator; the master is its environment.
interface conv33_window_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pix_valid;
  logic                  pix_ready;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  win_valid;
  logic                  win_ready;
  logic [DATA_WIDTH-1:0] win_0_0;
  logic [DATA_WIDTH-1:0] win_0_1;
  logic [DATA_WIDTH-1:0] win_0_2;
  logic [DATA_WIDTH-1:0] win_1_0;
  logic [DATA_WIDTH-1:0] win_1_1;
  logic [DATA_WIDTH-1:0] win_1_2;
  logic [DATA_WIDTH-1:0] win_2_0;
  logic [DATA_WIDTH-1:0] win_2_1;
  logic [DATA_WIDTH-1:0] win_2_2;
  logic                  frame_done;

  modport slave (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, frame_done,
    output win_0_0, win_0_1, win_0_2,
    output win_1_0, win_1_1, win_1_2,
    output win_2_0, win_2_1, win_2_2
  );

  modport master (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, frame_done,
    input  win_0_0, win_0_1, win_0_2,
    input  win_1_0, win_1_1, win_1_2,
    input  win_2_0, win_2_1, win_2_2
  );
endinterface

// File: rtl/conv33_window_gen.sv
// Raster-order pixel stream to 3x3 sliding window generator.
// Two line buffers plus a 3x3 shift window; single output register stage.
module conv33_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input logic             clk,
  input logic             rst,
  conv33_window_gen_if.slave io
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] r_q, r_d;
  logic          win_valid_q, win_valid_d;

  logic [2:0][2:0][DATA_WIDTH-1:0] win_q, win_d;

  logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2_q [IMG_WIDTH];

  logic accept;
  logic col_last;
  logic row_last;
  logic emit;

  assign io.pix_ready = !win_valid_q || io.win_ready;
  assign accept   = io.pix_valid && io.pix_ready;
  assign col_last = (c_q == C_LAST);
  assign row_last = (r_q == R_LAST);
  assign emit     = accept && (r_q >= RW'(2)) && (c_q >= CW'(2));

  always_comb begin
    c_d         = c_q;
    r_d         = r_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    state_d     = state_q;

    if (accept) begin
      c_d = col_last ? '0 : c_q + 1'b1;
      if (col_last) begin
        r_d = row_last ? '0 : r_q + 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      // newest column: rows r-2, r-1 from line buffers, row r live
      win_d[0][2] = lb2_q[c_q];
      win_d[1][2] = lb1_q[c_q];
      win_d[2][2] = io.pix_data;
    end

    if (emit) begin
      win_valid_d = 1'b1;
    end else if (io.win_ready) begin
      win_valid_d = 1'b0;
    end

    unique case (state_q)
      FILL: begin
        if (accept && col_last && (r_q == RW'(1))) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept && col_last && row_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= FILL;
      c_q         <= '0;
      r_q         <= '0;
      win_valid_q <= 1'b0;
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      r_q         <= r_d;
      win_valid_q <= win_valid_d;
      win_q       <= win_d;
    end
  end

  // stale rows are overwritten before any window reads them
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_q[c_q] <= lb1_q[c_q];
      lb1_q[c_q] <= io.pix_data;
    end
  end

  assign io.win_valid  = win_valid_q;
  assign io.frame_done = (state_q == DONE);
  assign io.win_0_0    = win_q[0][0];
  assign io.win_0_1    = win_q[0][1];
  assign io.win_0_2    = win_q[0][2];
  assign io.win_1_0    = win_q[1][0];
  assign io.win_1_1    = win_q[1][1];
  assign io.win_1_2    = win_q[1][2];
  assign io.win_2_0    = win_q[2][0];
  assign io.win_2_1    = win_q[2][1];
  assign io.win_2_2    = win_q[2][2];

endmodule

// File: tb/tb_conv33_window_gen.sv
// Self-checking bench for conv33_window_gen on a 4x4 image.
// Windows are predicted directly from the image array.
module tb_conv33_window_gen;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef struct packed {
    logic [8:0][DW-1:0] px;
    logic               last;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv33_window_gen_if #(.DATA_WIDTH(DW)) io();

  conv33_window_gen #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int fd_seen  = 0;
  int fd_exp   = 0;
  int acc_cnt  = 0;
  int rdy_mode = 0;

  logic [DW-1:0] img [H][W];
  win_t gen_q [$];
  win_t exp_q [$];

  int lit0 [4][9] = '{
    '{0, 1, 2, 4, 5, 6, 8, 9, 10},
    '{1, 2, 3, 5, 6, 7, 9, 10, 11},
    '{4, 5, 6, 8, 9, 10, 12, 13, 14},
    '{5, 6, 7, 9, 10, 11, 13, 14, 15}
  };
  int lit100 [9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0][DW-1:0] dut_win();
    logic [8:0][DW-1:0] w;
    w[0] = io.win_0_0; w[1] = io.win_0_1; w[2] = io.win_0_2;
    w[3] = io.win_1_0; w[4] = io.win_1_1; w[5] = io.win_1_2;
    w[6] = io.win_2_0; w[7] = io.win_2_1; w[8] = io.win_2_2;
    return w;
  endfunction

  function automatic logic [8:0][DW-1:0] lit_win(int v [9]);
    logic [8:0][DW-1:0] w;
    for (int j = 0; j < 9; j++) w[j] = v[j][DW-1:0];
    return w;
  endfunction

  task automatic fill_img(int rnd, int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = rnd ? DW'($urandom) : DW'(4 * r + c + base);
  endtask

  // every fully-interior 3x3 neighbourhood, raster order
  task automatic gen_windows();
    win_t e;
    gen_q.delete();
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.px[3 * i + j] = img[r - 2 + i][c - 2 + j];
        e.last = (r == H - 1) && (c == W - 1);
        gen_q.push_back(e);
      end
  endtask

  task automatic send_pixels(int n, int gaps);
    logic acc;
    int   t;
    for (int k = 0; k < n; k++) begin
      if (gaps != 0) begin
        int idle = $urandom_range(0, 2);
        io.pix_valid = 1'b0;
        repeat (idle) begin
          @(posedge clk);
          #1;
        end
      end
      io.pix_valid = 1'b1;
      io.pix_data  = img[k / W][k % W];
      t = 0;
      do begin
        @(negedge clk);
        acc = io.pix_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!acc && t < 200);
      if (!acc) check("accept_timeout", 0, 1);
      else acc_cnt++;
    end
    io.pix_valid = 1'b0;
  endtask

  task automatic send_frame(int gaps);
    gen_windows();
    foreach (gen_q[k]) exp_q.push_back(gen_q[k]);
    fd_exp++;
    send_pixels(W * H, gaps);
  endtask

  initial begin
    io.win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       io.win_ready = 1'b1;
        1:       io.win_ready = 1'($urandom_range(0, 1));
        default: io.win_ready = 1'b0;
      endcase
    end
  end

  logic               prev_stall = 1'b0;
  logic [8:0][DW-1:0] prev_win;
  logic [8:0][DW-1:0] cur;
  win_t               head;

  always @(negedge clk) begin
    cur = dut_win();
    if (rst) begin
      if (prev_stall) begin
        check("hold_valid", io.win_valid, 1);
        check("hold_data", cur, prev_win);
      end
      if (io.frame_done) begin
        fd_seen++;
        check("frame_done_on_last",
              io.win_valid && exp_q.size() > 0 && exp_q[0].last, 1);
      end
      if (io.win_valid && io.win_ready) begin
        check("window_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          head = exp_q.pop_front();
          check("window", cur, head.px);
        end
      end
      prev_stall = io.win_valid && !io.win_ready;
      prev_win   = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int t;
    io.pix_valid = 1'b0;
    io.pix_data  = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_win_valid", io.win_valid, 0);
    check("rst_frame_done", io.frame_done, 0);
    check("rst_pix_ready", io.pix_ready, 1);
    check("rst_win", dut_win(), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // pin the model against hand-computed windows
    fill_img(0, 0);
    gen_windows();
    check("model_count", gen_q.size(), 4);
    check("model_last", gen_q[3].last, 1);
    for (int k = 0; k < 4; k++)
      check("model_win", gen_q[k].px, lit_win(lit0[k]));
    fill_img(0, 100);
    gen_windows();
    check("model_win100", gen_q[0].px, lit_win(lit100));

    // plain frame, always ready
    rdy_mode = 0;
    fill_img(0, 0);
    send_frame(0);

    // downstream stall after the first window
    repeat (3) @(posedge clk);
    #1;
    rdy_mode = 2;
    acc_cnt  = 0;
    fill_img(0, 0);
    fork
      send_frame(0);
    join_none
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!io.win_valid && t < 100);
    check("stall_win_seen", io.win_valid, 1);
    repeat (6) begin
      @(negedge clk);
      check("stall_pix_ready", io.pix_ready, 0);
      check("stall_win", dut_win(), lit_win(lit0[0]));
      check("stall_acc", acc_cnt, 11);
    end
    rdy_mode = 1;
    wait fork;

    // back-to-back frames
    rdy_mode = 0;
    fill_img(0, 0);
    send_frame(0);
    fill_img(0, 100);
    send_frame(0);

    // reset in the middle of a frame
    repeat (3) @(posedge clk);
    #1;
    fill_img(0, 0);
    send_pixels(9, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_frame(0);

    // random valid gaps and random ready
    rdy_mode = 1;
    fill_img(0, 0);
    send_frame(1);
    for (int f = 0; f < 3; f++) begin
      fill_img(1, 0);
      send_frame(1);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    check("drain", exp_q.size(), 0);
    check("frame_done_count", fd_seen, fd_exp);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv33_window_gen.md
CONV33_WINDOW_GEN -- requirements
Module: conv33_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel and window element width.
REQ-002 SHALL have parameter IMG_WIDTH, default 28, pixels per row (>=3).
REQ-003 SHALL have parameter IMG_HEIGHT, default 28, rows per frame (>=3).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  one clock; reset is synchronous and active-low.
REQ-006 SHALL have port pix_valid  input  1  upstream pixel valid.
REQ-007 SHALL have port pix_ready  output  1  block accepts pixel this cycle.
REQ-008 SHALL have port pix_data  input  DATA_WIDTH  pixel, raster order, row-major.
REQ-009 SHALL have port win_valid  output  1  window outputs hold a valid 3x3 window.
REQ-010 SHALL have port win_ready  input  1  downstream (conv33 data_valid_in side) accepts window.
REQ-011 SHALL have port win_0_0  output  DATA_WIDTH  pixel (r-2, c-2).
REQ-012 SHALL have port win_0_1  output  DATA_WIDTH  pixel (r-2, c-1).
REQ-013 SHALL have port win_0_2  output  DATA_WIDTH  pixel (r-2, c).
REQ-014 SHALL have port win_1_0  output  DATA_WIDTH  pixel (r-1, c-2).
REQ-015 SHALL have port win_1_1  output  DATA_WIDTH  pixel (r-1, c-1).
REQ-016 SHALL have port win_1_2  output  DATA_WIDTH  pixel (r-1, c).
REQ-017 SHALL have port win_2_0  output  DATA_WIDTH  pixel (r, c-2).
REQ-018 SHALL have port win_2_1  output  DATA_WIDTH  pixel (r, c-1).
REQ-019 SHALL have port win_2_2  output  DATA_WIDTH  pixel (r, c), most recent accepted.
REQ-020 SHALL have port frame_done  output  1  one-cycle pulse, last pixel of frame accepted.

Function
REQ-021 SHALL accept a pixel exactly when pix_valid && pix_ready at a rising edge.
REQ-022 SHALL drive pix_ready = !win_valid || win_ready (combinational, single output stage).
REQ-023 SHALL track column c (0..IMG_WIDTH-1) and row r (0..IMG_HEIGHT-1) of the next pixel; c wraps to 0 and r increments on accepting c=IMG_WIDTH-1; both wrap to 0 after (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-024 SHALL keep two line buffers of IMG_WIDTH entries holding rows r-1 and r-2, plus a 3x3 shift window updated only on accepted pixels.
REQ-025 SHALL use FSM states FILL (r<2), RUN (r>=2), DONE; FILL->RUN on accepting last pixel of row 1; RUN->DONE on accepting last pixel of frame; DONE->FILL unconditionally next cycle.
REQ-026 SHALL, one cycle after accepting pixel (r,c) with r>=2 and c>=2, assert win_valid with the window of REQ-011..019 (latency 1 cycle).
REQ-027 SHALL produce exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame; no padding, no windows straddling row boundaries.
REQ-028 SHALL hold win_valid and all win_* stable while win_valid && !win_ready.
REQ-029 SHALL deassert win_valid after win_valid && win_ready unless a new window-producing pixel is accepted the same cycle, in which case win_valid stays high with the new window.
REQ-030 SHALL pulse frame_done for one cycle in DONE, coincident with the rising edge of the final window's win_valid.
REQ-031 SHALL not require line-buffer clearing between frames; rows 0-1 of the next frame overwrite stale data before any window is emitted.
REQ-032 SHALL accept a new frame's first pixel in the DONE cycle if pix_ready is high.

Reset
REQ-033 SHALL, on rst low at a rising edge, set win_valid=0, frame_done=0, all win_*=0, r=0, c=0, state=FILL; line-buffer contents need not be cleared.
REQ-034 SHALL, on reset mid-frame, discard the partial frame; the first pixel after reset is (0,0).

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 4r+c)
REQ-035 Stream 16 pixels, win_ready=1 -> 4 windows: (0,1,2,4,5,6,8,9,10), (1,2,3,5,6,7,9,10,11), (4,5,6,8,9,10,12,13,14), (5,6,7,9,10,11,13,14,15); frame_done once with the last.
REQ-036 win_ready=0 after first window -> win_* hold (0..10 window), pix_ready=0, no pixel consumed until win_ready=1.
REQ-037 Two back-to-back frames, second values +100 -> second frame's first window (100,101,102,104,105,106,108,109,110), no stale data.
REQ-038 rst low after 9 pixels, then full 16-pixel frame -> exactly 4 correct windows of REQ-035.
REQ-039 pix_valid toggling randomly, win_ready randomly -> window sequence identical to REQ-035, no drop or duplicate.
